// File: rtl/sram_bank_router.sv
// Routes one command packet at a time to one of NUM_BANKS 1rw1r SRAM banks and returns read data.
// Define SRAM_ROUTER_WACK_EN to also acknowledge write-only packets on the response channel.
module sram_bank_router #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  localparam int SEL_W    = $clog2(NUM_BANKS),
  localparam int MASK_W   = DATA_W / 8,
  localparam int PKT_W    = SEL_W + 2 + MASK_W + ADDR_W + DATA_W + 1 + ADDR_W
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  logic [PKT_W-1:0]            pkt,
  output logic [NUM_BANKS-1:0]        sram_csb0,
  output logic [NUM_BANKS-1:0]        sram_web0,
  output logic [NUM_BANKS*MASK_W-1:0] sram_wmask0,
  output logic [NUM_BANKS*ADDR_W-1:0] sram_addr0,
  output logic [NUM_BANKS*DATA_W-1:0] sram_din0,
  output logic [NUM_BANKS-1:0]        sram_csb1,
  output logic [NUM_BANKS*ADDR_W-1:0] sram_addr1,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout1,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [SEL_W-1:0]            rsp_bank,
  output logic                        rsp_rd0_valid,
  output logic                        rsp_rd1_valid,
  output logic [DATA_W-1:0]           rsp_data0,
  output logic [DATA_W-1:0]           rsp_data1,
  output logic                        rsp_wack,
  output logic                        err_sel
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [SEL_W:0]   BANK_LIMIT = (SEL_W + 1)'(NUM_BANKS);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(READ_LAT - 1);

`ifdef SRAM_ROUTER_WACK_EN
  localparam logic WACK_EN = 1'b1;
`else
  localparam logic WACK_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Packet field offsets, LSB upward
  localparam int P_CSB1  = ADDR_W;
  localparam int P_WDATA = ADDR_W + 1;
  localparam int P_ADDR0 = P_WDATA + DATA_W;
  localparam int P_WMASK = P_ADDR0 + ADDR_W;
  localparam int P_WEB0  = P_WMASK + MASK_W;
  localparam int P_CSB0  = P_WEB0 + 1;
  localparam int P_SEL   = P_CSB0 + 1;

  logic [SEL_W-1:0]  f_sel_s;
  logic              f_csb0_s;
  logic              f_web0_s;
  logic [MASK_W-1:0] f_wmask_s;
  logic [ADDR_W-1:0] f_addr0_s;
  logic [DATA_W-1:0] f_wdata_s;
  logic              f_csb1_s;
  logic [ADDR_W-1:0] f_addr1_s;

  assign f_sel_s   = pkt[P_SEL +: SEL_W];
  assign f_csb0_s  = pkt[P_CSB0];
  assign f_web0_s  = pkt[P_WEB0];
  assign f_wmask_s = pkt[P_WMASK +: MASK_W];
  assign f_addr0_s = pkt[P_ADDR0 +: ADDR_W];
  assign f_wdata_s = pkt[P_WDATA +: DATA_W];
  assign f_csb1_s  = pkt[P_CSB1];
  assign f_addr1_s = pkt[ADDR_W-1:0];

  logic [1:0]       state_r;
  logic [SEL_W-1:0] sel_r;
  logic             rd0_r;
  logic             rd1_r;
  logic             wr0_r;
  logic [CNT_W-1:0] cnt_r;

  logic [NUM_BANKS-1:0]        csb0_r, web0_r, csb1_r;
  logic [NUM_BANKS*MASK_W-1:0] wmask0_r;
  logic [NUM_BANKS*ADDR_W-1:0] addr0_r, addr1_r;
  logic [NUM_BANKS*DATA_W-1:0] din0_r;

  logic [NUM_BANKS-1:0]        csb0_s, web0_s, csb1_s;
  logic [NUM_BANKS*MASK_W-1:0] wmask0_s;
  logic [NUM_BANKS*ADDR_W-1:0] addr0_s, addr1_s;
  logic [NUM_BANKS*DATA_W-1:0] din0_s;

  logic              rsp_valid_r, rsp_rd0_valid_r, rsp_rd1_valid_r, rsp_wack_r, err_sel_r;
  logic [SEL_W-1:0]  rsp_bank_r;
  logic [DATA_W-1:0] rsp_data0_r, rsp_data1_r;
  logic [DATA_W-1:0] bank_dout0_s, bank_dout1_s;

  logic accept_s;
  logic sel_ok_s;
  logic issue_s;

  assign pkt_ready = (state_r == S_IDLE) && rst_n;
  assign accept_s  = pkt_valid && pkt_ready;
  assign sel_ok_s  = ({1'b0, f_sel_s} < BANK_LIMIT);
  assign issue_s   = accept_s && sel_ok_s;

  // Next-cycle pin image: only the addressed bank is driven, and only on an accepted packet
  always_comb begin
    csb0_s   = {NUM_BANKS{1'b1}};
    web0_s   = {NUM_BANKS{1'b1}};
    csb1_s   = {NUM_BANKS{1'b1}};
    wmask0_s = {(NUM_BANKS*MASK_W){1'b0}};
    addr0_s  = {(NUM_BANKS*ADDR_W){1'b0}};
    addr1_s  = {(NUM_BANKS*ADDR_W){1'b0}};
    din0_s   = {(NUM_BANKS*DATA_W){1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (issue_s && (f_sel_s == SEL_W'(b))) begin
        csb0_s[b]                     = f_csb0_s;
        web0_s[b]                     = f_web0_s;
        csb1_s[b]                     = f_csb1_s;
        wmask0_s[b*MASK_W +: MASK_W]  = f_wmask_s;
        addr0_s[b*ADDR_W +: ADDR_W]   = f_addr0_s;
        addr1_s[b*ADDR_W +: ADDR_W]   = f_addr1_s;
        din0_s[b*DATA_W +: DATA_W]    = f_wdata_s;
      end else begin
        csb0_s[b] = 1'b1;
        web0_s[b] = 1'b1;
        csb1_s[b] = 1'b1;
      end
    end
  end

  // Read-data mux for the bank that owns the current transaction
  always_comb begin
    bank_dout0_s = {DATA_W{1'b0}};
    bank_dout1_s = {DATA_W{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_dout0_s = (sel_r == SEL_W'(b)) ? sram_dout0[b*DATA_W +: DATA_W] : bank_dout0_s;
      bank_dout1_s = (sel_r == SEL_W'(b)) ? sram_dout1[b*DATA_W +: DATA_W] : bank_dout1_s;
    end
  end

  // Transaction state machine, registered SRAM pins and response registers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      sel_r           <= {SEL_W{1'b0}};
      rd0_r           <= 1'b0;
      rd1_r           <= 1'b0;
      wr0_r           <= 1'b0;
      cnt_r           <= {CNT_W{1'b0}};
      csb0_r          <= {NUM_BANKS{1'b1}};
      web0_r          <= {NUM_BANKS{1'b1}};
      csb1_r          <= {NUM_BANKS{1'b1}};
      wmask0_r        <= {(NUM_BANKS*MASK_W){1'b0}};
      addr0_r         <= {(NUM_BANKS*ADDR_W){1'b0}};
      addr1_r         <= {(NUM_BANKS*ADDR_W){1'b0}};
      din0_r          <= {(NUM_BANKS*DATA_W){1'b0}};
      rsp_valid_r     <= 1'b0;
      rsp_bank_r      <= {SEL_W{1'b0}};
      rsp_rd0_valid_r <= 1'b0;
      rsp_rd1_valid_r <= 1'b0;
      rsp_data0_r     <= {DATA_W{1'b0}};
      rsp_data1_r     <= {DATA_W{1'b0}};
      rsp_wack_r      <= 1'b0;
      err_sel_r       <= 1'b0;
    end else begin
      csb0_r   <= csb0_s;
      web0_r   <= web0_s;
      csb1_r   <= csb1_s;
      wmask0_r <= wmask0_s;
      addr0_r  <= addr0_s;
      addr1_r  <= addr1_s;
      din0_r   <= din0_s;
      case (state_r)
        S_IDLE: begin
          if (issue_s) begin
            state_r <= S_ISSUE;
            sel_r   <= f_sel_s;
            rd0_r   <= !f_csb0_s && f_web0_s;
            wr0_r   <= !f_csb0_s && !f_web0_s;
            rd1_r   <= !f_csb1_s;
          end else if (accept_s) begin
            err_sel_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (rd0_r || rd1_r) begin
            state_r <= S_WAIT;
            cnt_r   <= CNT_LOAD;
          end else if (WACK_EN && wr0_r) begin
            // Write-only acknowledge carries no read data
            state_r         <= S_RESP;
            rsp_valid_r     <= 1'b1;
            rsp_bank_r      <= sel_r;
            rsp_rd0_valid_r <= 1'b0;
            rsp_rd1_valid_r <= 1'b0;
            rsp_data0_r     <= {DATA_W{1'b0}};
            rsp_data1_r     <= {DATA_W{1'b0}};
            rsp_wack_r      <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r         <= S_RESP;
            rsp_valid_r     <= 1'b1;
            rsp_bank_r      <= sel_r;
            rsp_rd0_valid_r <= rd0_r;
            rsp_rd1_valid_r <= rd1_r;
            rsp_data0_r     <= rd0_r ? bank_dout0_s : {DATA_W{1'b0}};
            rsp_data1_r     <= rd1_r ? bank_dout1_s : {DATA_W{1'b0}};
            rsp_wack_r      <= WACK_EN && wr0_r;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign sram_csb0     = csb0_r;
  assign sram_web0     = web0_r;
  assign sram_wmask0   = wmask0_r;
  assign sram_addr0    = addr0_r;
  assign sram_din0     = din0_r;
  assign sram_csb1     = csb1_r;
  assign sram_addr1    = addr1_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_bank      = rsp_bank_r;
  assign rsp_rd0_valid = rsp_rd0_valid_r;
  assign rsp_rd1_valid = rsp_rd1_valid_r;
  assign rsp_data0     = rsp_data0_r;
  assign rsp_data1     = rsp_data1_r;
  assign rsp_wack      = rsp_wack_r;
  assign err_sel       = err_sel_r;

endmodule

// File: tb/tb_sram_bank_router.sv
// Directed bench for sram_bank_router: a default instance backed by a small SRAM model,
// and a 3-bank, READ_LAT=2 instance with fixed dout patterns for select-error and reset cases.
module tb_sram_bank_router;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

`ifdef SRAM_ROUTER_WACK_EN
  localparam logic WACK_EXP = 1'b1;
`else
  localparam logic WACK_EXP = 1'b0;
`endif

  // instance A: defaults (2 banks, READ_LAT 1)
  logic        rst_n, pkt_valid_a, pkt_ready_a, rsp_valid_a, rsp_ready_a;
  logic [55:0] pkt_a;
  logic [1:0]  csb0_a, web0_a, csb1_a;
  logic [7:0]  wmask0_a;
  logic [15:0] addr0_a, addr1_a;
  logic [63:0] din0_a, dout0_a, dout1_a;
  logic [0:0]  rsp_bank_a;
  logic        rd0v_a, rd1v_a, wack_a, err_a;
  logic [31:0] data0_a, data1_a;

  sram_bank_router dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .pkt_valid(pkt_valid_a), .pkt_ready(pkt_ready_a), .pkt(pkt_a),
    .sram_csb0(csb0_a), .sram_web0(web0_a), .sram_wmask0(wmask0_a), .sram_addr0(addr0_a),
    .sram_din0(din0_a), .sram_csb1(csb1_a), .sram_addr1(addr1_a), .sram_dout0(dout0_a),
    .sram_dout1(dout1_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_bank(rsp_bank_a),
    .rsp_rd0_valid(rd0v_a), .rsp_rd1_valid(rd1v_a), .rsp_data0(data0_a), .rsp_data1(data1_a),
    .rsp_wack(wack_a), .err_sel(err_a)
  );

  // instance B: 3 banks, READ_LAT 2
  logic        rst_n_b, pkt_valid_b, pkt_ready_b, rsp_valid_b, rsp_ready_b;
  logic [56:0] pkt_b;
  logic [2:0]  csb0_b, web0_b, csb1_b;
  logic [11:0] wmask0_b;
  logic [23:0] addr0_b, addr1_b;
  logic [95:0] din0_b, dout0_b, dout1_b;
  logic [1:0]  rsp_bank_b;
  logic        rd0v_b, rd1v_b, wack_b, err_b;
  logic [31:0] data0_b, data1_b;

  assign dout0_b = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
  assign dout1_b = {32'hF2F2F2F2, 32'hE1E1E1E1, 32'hD0D0D0D0};

  sram_bank_router #(.NUM_BANKS(3), .READ_LAT(2)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n_b), .pkt_valid(pkt_valid_b), .pkt_ready(pkt_ready_b), .pkt(pkt_b),
    .sram_csb0(csb0_b), .sram_web0(web0_b), .sram_wmask0(wmask0_b), .sram_addr0(addr0_b),
    .sram_din0(din0_b), .sram_csb1(csb1_b), .sram_addr1(addr1_b), .sram_dout0(dout0_b),
    .sram_dout1(dout1_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_bank(rsp_bank_b),
    .rsp_rd0_valid(rd0v_b), .rsp_rd1_valid(rd1v_b), .rsp_data0(data0_b), .rsp_data1(data1_b),
    .rsp_wack(wack_b), .err_sel(err_b)
  );

  // 1rw1r SRAM model for instance A: samples on the edge, dout valid one cycle later
  logic [31:0] mem [0:1][0:255];
  always @(posedge clk_in) begin
    for (int b = 0; b < 2; b++) begin
      if (!csb0_a[b]) begin
        if (!web0_a[b]) begin
          for (int k = 0; k < 4; k++) begin
            if (wmask0_a[b*4+k]) mem[b][addr0_a[b*8 +: 8]][k*8 +: 8] <= din0_a[b*32 + k*8 +: 8];
          end
        end else begin
          dout0_a[b*32 +: 32] <= mem[b][addr0_a[b*8 +: 8]];
        end
      end
      if (!csb1_a[b]) dout1_a[b*32 +: 32] <= mem[b][addr1_a[b*8 +: 8]];
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [56:0] mk(input logic [1:0] sel, input logic csb0, input logic web0,
                                     input logic [3:0] wmask, input logic [7:0] addr0,
                                     input logic [31:0] wdata, input logic csb1, input logic [7:0] addr1);
    return {sel, csb0, web0, wmask, addr0, wdata, csb1, addr1};
  endfunction

  // Waits (bounded) for pkt_ready, then presents the packet for one accept edge
  task automatic send_a(input logic [56:0] p);
    int n = 0;
    while (!pkt_ready_a && n < 20) begin
      tick();
      n++;
    end
    check("ready_a", pkt_ready_a, 1'b1);
    pkt_a       = p[55:0];
    pkt_valid_a = 1'b1;
    tick();
    pkt_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [56:0] p);
    int n = 0;
    while (!pkt_ready_b && n < 20) begin
      tick();
      n++;
    end
    check("ready_b", pkt_ready_b, 1'b1);
    pkt_b       = p;
    pkt_valid_b = 1'b1;
    tick();
    pkt_valid_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    pkt_valid_a = 1'b1; pkt_valid_b = 1'b1;
    pkt_a = 56'h0; pkt_b = 57'h0;
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;

    // reset with pkt_valid held high
    repeat (3) tick();
    check("rst_ready_a", pkt_ready_a, 1'b0);
    check("rst_ready_b", pkt_ready_b, 1'b0);
    check("rst_csb0_a", csb0_a, 2'b11);
    check("rst_web0_a", web0_a, 2'b11);
    check("rst_csb1_a", csb1_a, 2'b11);
    check("rst_din0_a", din0_a, 64'h0);
    check("rst_csb0_b", csb0_b, 3'b111);
    check("rst_rsp_a", rsp_valid_a, 1'b0);
    check("rst_err_a", err_a, 1'b0);
    pkt_valid_a = 1'b0; pkt_valid_b = 1'b0;
    rst_n = 1'b1; rst_n_b = 1'b1;
    tick();
    check("ready_after_rst", pkt_ready_a, 1'b1);

    // write bank 1
    send_a(mk(2'd1, 1'b0, 1'b0, 4'hF, 8'h12, 32'hDEADBEEF, 1'b1, 8'h00));
    check("wr_csb0", csb0_a, 2'b01);
    check("wr_web0", web0_a, 2'b01);
    check("wr_addr0", addr0_a, 16'h1200);
    check("wr_din0", din0_a, {32'hDEADBEEF, 32'h0});
    check("wr_wmask", wmask0_a, 8'hF0);
    check("wr_csb1", csb1_a, 2'b11);
    check("wr_busy", pkt_ready_a, 1'b0);
    tick();
    check("wr_csb0_idle", csb0_a, 2'b11);
    check("wr_web0_idle", web0_a, 2'b11);
`ifdef SRAM_ROUTER_WACK_EN
    check("wack_valid", rsp_valid_a, 1'b1);
    check("wack_flag", wack_a, 1'b1);
    check("wack_rd0v", rd0v_a, 1'b0);
    check("wack_data0", data0_a, 32'h0);
    check("wack_busy", pkt_ready_a, 1'b0);
    tick();
    check("wack_done", rsp_valid_a, 1'b0);
`else
    check("wr_no_rsp", rsp_valid_a, 1'b0);
    check("wr_ready_a1", pkt_ready_a, 1'b1);
`endif

    // preload bank 0 through the router
    send_a(mk(2'd0, 1'b0, 1'b0, 4'hF, 8'h05, 32'h11111111, 1'b1, 8'h00));
    send_a(mk(2'd0, 1'b0, 1'b0, 4'hF, 8'h06, 32'h22222222, 1'b1, 8'h00));

    // read bank 1, port 0
    send_a(mk(2'd1, 1'b0, 1'b1, 4'h0, 8'h12, 32'h0, 1'b1, 8'h00));
    check("rd_csb0", csb0_a, 2'b01);
    check("rd_web0", web0_a, 2'b11);
    tick();
    check("rd_latency", rsp_valid_a, 1'b0);
    tick();
    check("rd_valid", rsp_valid_a, 1'b1);
    check("rd_data0", data0_a, 32'hDEADBEEF);
    check("rd_bank", rsp_bank_a, 1'b1);
    check("rd_rd0v", rd0v_a, 1'b1);
    check("rd_rd1v", rd1v_a, 1'b0);
    check("rd_data1", data1_a, 32'h0);
    check("rd_wack", wack_a, 1'b0);
    tick();
    check("rd_done", rsp_valid_a, 1'b0);
    check("rd_ready", pkt_ready_a, 1'b1);

    // dual-port read with response backpressure
    rsp_ready_a = 1'b0;
    send_a(mk(2'd0, 1'b0, 1'b1, 4'h0, 8'h05, 32'h0, 1'b0, 8'h06));
    tick();
    tick();
    check("dp_valid", rsp_valid_a, 1'b1);
    check("dp_data0", data0_a, 32'h11111111);
    check("dp_data1", data1_a, 32'h22222222);
    check("dp_rd0v", rd0v_a, 1'b1);
    check("dp_rd1v", rd1v_a, 1'b1);
    check("dp_bank", rsp_bank_a, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", rsp_valid_a, 1'b1);
      check("hold_data0", data0_a, 32'h11111111);
      check("hold_data1", data1_a, 32'h22222222);
      check("hold_busy", pkt_ready_a, 1'b0);
    end
    rsp_ready_a = 1'b1;
    tick();
    check("dp_done", rsp_valid_a, 1'b0);

    // write on port 0 combined with a port-1 read
    send_a(mk(2'd0, 1'b0, 1'b0, 4'h3, 8'h07, 32'h0000ABCD, 1'b0, 8'h05));
    tick();
    tick();
    check("wr1_valid", rsp_valid_a, 1'b1);
    check("wr1_data1", data1_a, 32'h11111111);
    check("wr1_rd0v", rd0v_a, 1'b0);
    check("wr1_data0", data0_a, 32'h0);
    check("wr1_wack", wack_a, WACK_EXP);
    tick();

    // out-of-range select on the 3-bank instance
    check("b_err_init", err_b, 1'b0);
    send_b(mk(2'd3, 1'b0, 1'b0, 4'hF, 8'h10, 32'h1, 1'b0, 8'h10));
    check("bad_err", err_b, 1'b1);
    check("bad_csb0", csb0_b, 3'b111);
    check("bad_web0", web0_b, 3'b111);
    check("bad_csb1", csb1_b, 3'b111);
    check("bad_ready", pkt_ready_b, 1'b1);
    check("bad_no_rsp", rsp_valid_b, 1'b0);
    send_b(mk(2'd2, 1'b0, 1'b1, 4'h0, 8'h33, 32'h0, 1'b0, 8'h44));
    check("b_csb0", csb0_b, 3'b011);
    check("b_addr0", addr0_b, 24'h330000);
    check("b_csb1", csb1_b, 3'b011);
    check("b_addr1", addr1_b, 24'h440000);
    tick();
    tick();
    check("b_latency", rsp_valid_b, 1'b0);
    tick();
    check("b_valid", rsp_valid_b, 1'b1);
    check("b_data0", data0_b, 32'hC2C2C2C2);
    check("b_data1", data1_b, 32'hF2F2F2F2);
    check("b_bank", rsp_bank_b, 2'd2);
    check("b_err_sticky", err_b, 1'b1);
    tick();
    check("b_done", rsp_valid_b, 1'b0);

    // reset while waiting for read data
    send_b(mk(2'd1, 1'b0, 1'b1, 4'h0, 8'h01, 32'h0, 1'b1, 8'h00));
    tick();
    rst_n_b = 1'b0;
    tick();
    check("mr_rsp", rsp_valid_b, 1'b0);
    check("mr_csb0", csb0_b, 3'b111);
    check("mr_ready_low", pkt_ready_b, 1'b0);
    check("mr_err_clr", err_b, 1'b0);
    rst_n_b = 1'b1;
    tick();
    check("mr_ready_high", pkt_ready_b, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_rsp", rsp_valid_b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
